// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// instruction classes, immediate types and datapath mux selects.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [2:0] IMM_I_TYPE = 3'd0;
    localparam logic [2:0] IMM_S_TYPE = 3'd1;
    localparam logic [2:0] IMM_B_TYPE = 3'd2;
    localparam logic [2:0] IMM_U_TYPE = 3'd3;
    localparam logic [2:0] IMM_J_TYPE = 3'd4;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEMDATA = 2'd1;
    localparam logic [1:0] RES_ALURES  = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_EXECU    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR_ADR = 4'd10,
        S_JALR_PC  = 4'd11,
        S_ALUWB    = 4'd12,
        S_BRANCH   = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    typedef enum logic [3:0] {
        CLS_LOAD, CLS_STORE, CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC,
        CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_FENCE, CLS_ILLEGAL
    } cls_e;

endpackage

// File: rtl/multicycle_ctrl_instr_class_dec.sv
// Combinational instruction classifier: opcode class, encoding legality and
// branch outcome from the current ALU compare flags.
module instr_class_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    output cls_e        cls,
    output logic        legal,
    output logic        branch_taken
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_ok;
    logic       unused_fields;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Alternate funct7 is only meaningful for SUB/SRA (and SRAI).
    assign f7_ok = (f7 == 7'b0000000) ||
                   (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));

    always_comb begin
        cls   = CLS_ILLEGAL;
        legal = 1'b1;
        case (opc)
            OPC_LOAD:    cls = CLS_LOAD;
            OPC_STORE:   cls = CLS_STORE;
            OPC_OP:      begin cls = CLS_OP; legal = f7_ok; end
            OPC_OPIMM: begin
                cls = CLS_OPIMM;
                if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) legal = f7_ok;
            end
            OPC_LUI:     cls = CLS_LUI;
            OPC_AUIPC:   cls = CLS_AUIPC;
            OPC_JAL:     cls = CLS_JAL;
            OPC_JALR:    cls = CLS_JALR;
            OPC_BRANCH:  begin cls = CLS_BRANCH; legal = (f3[2:1] != 2'b01); end
            OPC_MISCMEM: cls = CLS_FENCE;
            default:     begin cls = CLS_ILLEGAL; legal = 1'b0; end
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (f3)
            3'b000:  branch_taken = alu_zero;
            3'b001:  branch_taken = !alu_zero;
            3'b100:  branch_taken = alu_lt;
            3'b101:  branch_taken = !alu_lt;
            3'b110:  branch_taken = alu_ltu;
            3'b111:  branch_taken = !alu_ltu;
            default: branch_taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over one ALU and one memory port.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [2:0]  imm_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        trap
);
    state_e state_q, state_d;
    logic   trap_q, trap_d;
    cls_e   cls;
    logic   legal, br_taken;

    instr_class_dec u_dec (
        .instr        (instr),
        .alu_zero     (alu_zero),
        .alu_lt       (alu_lt),
        .alu_ltu      (alu_ltu),
        .cls          (cls),
        .legal        (legal),
        .branch_taken (br_taken)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_LOAD, CLS_STORE:  state_d = S_MEMADR;
                    CLS_OP:               state_d = legal ? S_EXECR : S_TRAP;
                    CLS_OPIMM:            state_d = legal ? S_EXECI : S_TRAP;
                    CLS_LUI, CLS_AUIPC:   state_d = S_EXECU;
                    CLS_JAL:              state_d = S_JAL;
                    CLS_JALR:             state_d = S_JALR_ADR;
                    CLS_BRANCH:           state_d = S_BRANCH;
                    CLS_FENCE:            state_d = S_FETCH;
                    default:              state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (cls == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_EXECU, S_JAL, S_JALR_PC: state_d = S_ALUWB;
            S_JALR_ADR: state_d = S_JALR_PC;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = legal ? S_FETCH : S_TRAP;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        trap_d = trap_q | (state_d == S_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        imm_src    = IMM_I_TYPE;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                imm_src   = (cls == CLS_JAL) ? IMM_J_TYPE : IMM_B_TYPE;
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                imm_src   = (cls == CLS_STORE) ? IMM_S_TYPE : IMM_I_TYPE;
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  begin mem_req = 1'b1; adr_src = 1'b1; end
            S_MEMWB:    begin result_src = RES_MEMDATA; reg_write = 1'b1; end
            S_MEMWRITE: begin mem_req = 1'b1; mem_we = 1'b1; adr_src = 1'b1; end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECU: begin
                imm_src   = IMM_U_TYPE;
                alu_src_a = (cls == CLS_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            // ALUOut holds the jump target; the ALU forms the link value.
            S_JAL, S_JALR_PC: begin
                pc_write  = 1'b1;
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
            end
            S_JALR_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                pc_write  = legal & br_taken;
            end
            default: ;
        endcase
        // Enables fall with rst_n itself, not at the next edge.
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign trap = trap_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction table plus hand sequences
// for wait states, traps and reset during a memory transfer.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, trap;
    logic [2:0]  imm_src;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;

    int n_chk = 0;
    int n_fail = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .imm_src(imm_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        z, lt, ltu;
        int          cyc, nreg, npc;
        logic        trp;
    } vec_t;

    vec_t vecs [25];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the FSM at the first cycle of FETCH, 1 time unit after the edge.
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic z, lt, ltu,
                             output int cyc, nreg, npc, output logic trp);
        int  n;
        bit  done;
        instr = ins; alu_zero = z; alu_lt = lt; alu_ltu = ltu; mem_ready = 1'b1;
        n = 0; nreg = 0; npc = 0; trp = 1'b0; done = 1'b0;
        while (!done) begin
            #2;
            if (trap) begin
                trp = 1'b1; done = 1'b1;
            end else if (n > 0 && mem_req && !adr_src) begin
                done = 1'b1;
            end else if (n >= 40) begin
                done = 1'b1;
            end else begin
                nreg += int'(reg_write);
                npc  += int'(pc_write);
                n++;
                tick();
            end
        end
        cyc = n;
    endtask

    initial begin
        int   cyc, nreg, npc, held, quiet;
        logic trp;

        vecs[0]  = '{32'h003100B3, 0, 0, 0, 4, 1, 1, 0}; // add
        vecs[1]  = '{32'h40310133, 0, 0, 0, 4, 1, 1, 0}; // sub
        vecs[2]  = '{32'h4031D133, 0, 0, 0, 4, 1, 1, 0}; // sra
        vecs[3]  = '{32'h40311133, 0, 0, 0, 2, 0, 1, 1}; // sll with bad funct7
        vecs[4]  = '{32'h02310133, 0, 0, 0, 2, 0, 1, 1}; // mul: funct7 0000001
        vecs[5]  = '{32'h00508093, 0, 0, 0, 4, 1, 1, 0}; // addi
        vecs[6]  = '{32'h4030D093, 0, 0, 0, 4, 1, 1, 0}; // srai
        vecs[7]  = '{32'h40309093, 0, 0, 0, 2, 0, 1, 1}; // slli with bad funct7
        vecs[8]  = '{32'h40008093, 0, 0, 0, 4, 1, 1, 0}; // addi, large imm
        vecs[9]  = '{32'h123450B7, 0, 0, 0, 4, 1, 1, 0}; // lui
        vecs[10] = '{32'h00001097, 0, 0, 0, 4, 1, 1, 0}; // auipc
        vecs[11] = '{32'h008000EF, 0, 0, 0, 4, 1, 2, 0}; // jal
        vecs[12] = '{32'h000080E7, 0, 0, 0, 5, 1, 2, 0}; // jalr
        vecs[13] = '{32'h0000A083, 0, 0, 0, 5, 1, 1, 0}; // lw
        vecs[14] = '{32'h0020A023, 0, 0, 0, 4, 0, 1, 0}; // sw
        vecs[15] = '{32'h00208463, 1, 0, 0, 3, 0, 2, 0}; // beq taken
        vecs[16] = '{32'h00208463, 0, 0, 0, 3, 0, 1, 0}; // beq not taken
        vecs[17] = '{32'h00209463, 0, 0, 0, 3, 0, 2, 0}; // bne taken
        vecs[18] = '{32'h0020C463, 0, 1, 0, 3, 0, 2, 0}; // blt taken
        vecs[19] = '{32'h0020D463, 0, 1, 0, 3, 0, 1, 0}; // bge not taken
        vecs[20] = '{32'h0020E463, 0, 0, 1, 3, 0, 2, 0}; // bltu taken
        vecs[21] = '{32'h0020F463, 0, 0, 0, 3, 0, 2, 0}; // bgeu taken
        vecs[22] = '{32'h0020A463, 1, 0, 0, 3, 0, 1, 1}; // branch funct3 010
        vecs[23] = '{32'h0000000F, 0, 0, 0, 2, 0, 1, 0}; // fence as nop
        vecs[24] = '{32'h00000000, 0, 0, 0, 2, 0, 1, 1}; // unknown opcode

        // Reset state, with mem_ready already high.
        rst_n = 1'b0; mem_ready = 1'b1;
        #2;
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_ir_write", int'(ir_write), 0);
        chk("rst_pc_write", int'(pc_write), 0);
        chk("rst_reg_write", int'(reg_write), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_trap", int'(trap), 0);
        chk("rst_alu_src_b", int'(alu_src_b), 2);
        chk("rst_alu_src_a", int'(alu_src_a), 0);
        @(posedge clk); #1; rst_n = 1'b1; #1;
        chk("release_mem_req", int'(mem_req), 1);

        // Table of whole instructions with no wait states.
        do_reset();
        foreach (vecs[i]) begin
            run_instr(vecs[i].ins, vecs[i].z, vecs[i].lt, vecs[i].ltu, cyc, nreg, npc, trp);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("vec%0d_reg_write", i), nreg, vecs[i].nreg);
            chk($sformatf("vec%0d_pc_write", i), npc, vecs[i].npc);
            chk($sformatf("vec%0d_trap", i), int'(trp), int'(vecs[i].trp));
            if (trp) do_reset();
        end

        // ADD cycle by cycle.
        do_reset();
        instr = 32'h003100B3; alu_zero = 0; alu_lt = 0; alu_ltu = 0;
        #2;
        chk("add_c1_mem_req", int'(mem_req), 1);
        chk("add_c1_ir_write", int'(ir_write), 1);
        tick(); #2;
        chk("add_c2_mem_req", int'(mem_req), 0);
        chk("add_c2_imm_src", int'(imm_src), 2);
        chk("add_c2_src_a", int'(alu_src_a), 1);
        tick(); #2;
        chk("add_c3_alu_op", int'(alu_op), 2);
        chk("add_c3_src_a", int'(alu_src_a), 2);
        chk("add_c3_reg_write", int'(reg_write), 0);
        tick(); #2;
        chk("add_c4_reg_write", int'(reg_write), 1);
        chk("add_c4_result_src", int'(result_src), 0);
        tick(); #2;
        chk("add_c5_mem_req", int'(mem_req), 1);
        chk("add_c5_reg_write", int'(reg_write), 0);

        // LW with three wait cycles in MEMREAD.
        do_reset();
        instr = 32'h0000A083;
        #2; tick(); #2;
        chk("lw_decode_imm_src", int'(imm_src), 2);
        tick(); mem_ready = 1'b0; #2;
        chk("lw_memadr_imm_src", int'(imm_src), 0);
        chk("lw_memadr_src_a", int'(alu_src_a), 2);
        chk("lw_memadr_mem_req", int'(mem_req), 0);
        held = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) mem_ready = 1'b1;
            #2;
            held += int'(mem_req && adr_src && !mem_we && !reg_write);
        end
        chk("lw_req_held", held, 4);
        tick(); #2;
        chk("lw_wb_result_src", int'(result_src), 1);
        chk("lw_wb_reg_write", int'(reg_write), 1);
        tick(); #2;
        chk("lw_next_fetch", int'(mem_req && !adr_src), 1);
        chk("lw_next_reg_write", int'(reg_write), 0);

        // BEQ: pc_write follows the flag within the BRANCH cycle.
        do_reset();
        instr = 32'h00208463; alu_zero = 1'b1;
        #2; tick(); #2;
        chk("beq_decode_imm_src", int'(imm_src), 2);
        tick(); #2;
        chk("beq_taken_pc_write", int'(pc_write), 1);
        chk("beq_alu_op", int'(alu_op), 1);
        alu_zero = 1'b0; #1;
        chk("beq_not_taken_pc_write", int'(pc_write), 0);

        // JAL selects the J immediate in DECODE.
        do_reset();
        instr = 32'h008000EF;
        #2; tick(); #2;
        chk("jal_decode_imm_src", int'(imm_src), 4);

        // JALR step by step.
        do_reset();
        instr = 32'h000080E7;
        #2; tick(); #2; tick(); #2;
        chk("jalr_adr_src_a", int'(alu_src_a), 2);
        chk("jalr_adr_pc_write", int'(pc_write), 0);
        tick(); #2;
        chk("jalr_pc_pc_write", int'(pc_write), 1);
        chk("jalr_pc_result_src", int'(result_src), 0);
        chk("jalr_pc_src_b", int'(alu_src_b), 2);
        tick(); #2;
        chk("jalr_wb_reg_write", int'(reg_write), 1);
        tick(); #2;
        chk("jalr_next_fetch", int'(mem_req && !adr_src), 1);

        // ECALL traps, stays trapped, and reset clears it.
        do_reset();
        instr = 32'h00000073;
        #2; tick(); #2; tick(); #2;
        chk("ecall_trap", int'(trap), 1);
        quiet = 0;
        for (int k = 0; k < 20; k++) begin
            tick(); #2;
            quiet += int'(trap && !mem_req && !pc_write && !reg_write && !ir_write);
        end
        chk("ecall_trap_sticky", quiet, 20);
        rst_n = 1'b0; #1;
        chk("ecall_reset_trap", int'(trap), 0);
        chk("ecall_reset_mem_req", int'(mem_req), 0);
        @(posedge clk); #1; rst_n = 1'b1; #1;
        chk("ecall_restart_fetch", int'(mem_req && !adr_src), 1);

        // Reset while a store waits for memory.
        do_reset();
        instr = 32'h0020A023;
        #2; tick(); #2; tick(); mem_ready = 1'b0; #2; tick(); #2;
        chk("sw_wait_mem_req", int'(mem_req), 1);
        chk("sw_wait_mem_we", int'(mem_we), 1);
        chk("sw_wait_adr_src", int'(adr_src), 1);
        tick(); #2;
        chk("sw_wait_held", int'(mem_req && mem_we && adr_src), 1);
        #1; rst_n = 1'b0; #1;
        chk("sw_abort_mem_req", int'(mem_req), 0);
        chk("sw_abort_mem_we", int'(mem_we), 0);
        @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b1; #1;
        chk("sw_restart_fetch", int'(mem_req && !adr_src && !mem_we), 1);
        tick(); #2;
        chk("sw_restart_decode_src_a", int'(alu_src_a), 1);
        chk("sw_restart_decode_mem_req", int'(mem_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. Sequences one instruction at a time through fetch, decode, execute, memory and writeback over a shared ALU and a single unified memory port. Drives the immediate extender's `imm_src`, the ALU/result muxes, PC/IR/register-file write enables and the memory request handshake. Sits beside the datapath and consumes only the latched instruction register and ALU flags.

## Interface
- No parameters. Encodings come from `defines.vh`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr` in 32: IR contents, valid from DECODE onward.
- `alu_zero`, `alu_lt`, `alu_ltu` in 1 each: flags from the current-cycle ALU result (rs1−rs2).
- `mem_ready` in 1: memory accepts/completes the request this cycle.
- `mem_req` out 1, `mem_we` out 1: memory request and write strobe.
- `adr_src` out 1: memory address, 0=PC, 1=ALUOut.
- `ir_write`, `pc_write`, `reg_write` out 1 each: register write enables.
- `imm_src` out 3: extender select (`IMM_*_TYPE`).
- `alu_src_a` out 2: 0=PC, 1=oldPC, 2=rs1, 3=zero.
- `alu_src_b` out 2: 0=rs2, 1=imm, 2=const 4.
- `alu_op` out 2: 0=add, 1=sub/compare, 2=decode funct3/funct7.
- `result_src` out 2: 0=ALUOut register, 1=memory data, 2=ALU result.
- `trap` out 1: sticky illegal-instruction flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, EXECU, JAL, JALR_ADR, JALR_PC, ALUWB, BRANCH, TRAP.
- FETCH: `mem_req`=1, `adr_src`=0, a=PC, b=4, add. Hold until `mem_ready`. On ready: `ir_write`=1 and `pc_write`=1 (PC+4), then go to DECODE.
- DECODE: a=oldPC, b=imm, add. ALUOut receives the branch/jump target. `imm_src`=J for JAL, else B.
- DECODE dispatch on opcode:
  - load→MEMADR; store→MEMADR; OP→EXECR; OP-IMM→EXECI.
  - LUI/AUIPC→EXECU; JAL→JAL; JALR→JALR_ADR; BRANCH→BRANCH.
  - MISC-MEM (FENCE)→FETCH as a NOP.
  - SYSTEM or any other opcode→TRAP.
- MEMADR: a=rs1, b=imm, add. `imm_src`=I for load, S for store. Go to MEMREAD or MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. Hold until ready, then MEMWB.
- MEMWB: `result_src`=1, `reg_write`=1, then FETCH.
- MEMWRITE: `mem_req`=1, `mem_we`=1, `adr_src`=1. Hold until ready, then FETCH.
- EXECR: a=rs1, b=rs2, `alu_op`=2. Then ALUWB.
- EXECI: a=rs1, b=imm I, `alu_op`=2. Then ALUWB.
- EXECU: `imm_src`=U, b=imm, add. a=zero for LUI, oldPC for AUIPC. Then ALUWB.
- ALUWB: `result_src`=0, `reg_write`=1, then FETCH.
- JAL: `result_src`=0, `pc_write`=1, a=oldPC, b=4. Then ALUWB.
- JALR_ADR: a=rs1, b=imm I, add. Then JALR_PC.
- JALR_PC: same outputs as JAL. Then ALUWB.
- BRANCH: a=rs1, b=rs2, sub, `result_src`=0. `pc_write` = taken, then FETCH.
  - Taken by funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
  - funct3 010/011 → TRAP with no PC write.
- Decode checks:
  - funct7 must be 0000000 (or 0100000 for SUB/SRA) on OP.
  - Shift-immediate funct7 is checked the same way.
  - Violation → TRAP.
- TRAP: all enables 0, `trap`=1. Remains until reset.
- Don't-care outputs are driven 0 in every state (no latches, no X).

## Timing
- Outputs are Moore, decoded from the state register. `pc_write` in BRANCH also depends on the flags.
- Reset (async assert, synchronous deassert handled at the top level): state=FETCH. `trap`=0.
- During reset all outputs are 0 except FETCH's mux selects. `mem_req` rises on the first clock-edge-free cycle after release.
- Reset mid-instruction aborts at once. A pending `mem_req` drops combinationally with `rst_n` low.
- Memory handshake:
  - `mem_req`, `mem_we` and `adr_src` stay stable while waiting.
  - A transfer completes in a cycle where `mem_req` && `mem_ready`.
  - `mem_ready` without `mem_req` is ignored.
- Latency with zero wait states:
  - Branch 3 cycles; R/I/U/JAL/store 4; load/JALR 5.
  - Each wait cycle adds one.
- `ir_write` and `pc_write` in FETCH pulse only in the `mem_ready` cycle.

## Structure
- Opcode values, state encoding (4-bit localparams) and mux select encodings go in `defines.vh`, alongside the existing `IMM_*_TYPE` codes.
- Natural sub-module: `instr_class_dec`, combinational. Maps `instr` to {op class, legal, branch_taken given flags}.

## Test plan
- Reset then ADD (0x003100B3), `mem_ready` tied 1 → states FETCH, DECODE, EXECR, ALUWB. `reg_write`=1 only in cycle 4; next `mem_req` at cycle 5.
- LW (0x0000A083) with `mem_ready` low 3 cycles in MEMREAD → `mem_req`/`adr_src`=1 held 4 cycles; `imm_src`=I in MEMADR; `result_src`=1 and `reg_write`=1 once.
- BEQ (0x00208463), alu_zero=1 → `pc_write`=1 in cycle 3, `imm_src`=B in DECODE. Repeat with alu_zero=0 → `pc_write`=0. funct3=010 → `trap`=1.
- JALR (0x000080E7) → JALR_ADR, JALR_PC with `pc_write`=1 and `result_src`=0, then ALUWB `reg_write`=1. Total 5 cycles.
- ECALL (0x00000073) → TRAP. `trap` stays 1 and no `mem_req` for 20 cycles. `rst_n` low → `trap`=0, FETCH.
- Assert `rst_n` low during MEMWRITE wait → `mem_req`/`mem_we` drop the same cycle; after release the FSM restarts at FETCH.
